// File: rtl/bar_pkg.sv
// Shared types for both ends of the bar streaming interface.
package bar_pkg;
    localparam int BAR_WIDTH = 32;

    typedef logic [BAR_WIDTH-1:0] bar_word_t;
    typedef logic [31:0]          bar_xfer_cnt_t;
endpackage

// File: rtl/bar_fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module bar_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bar_stream_source.sv
// Producer end of the bar interface: local push port -> FIFO -> valid/ready output
// holding the head word stable until it is accepted.
module bar_stream_source
    import bar_pkg::*;
#(
    parameter int WIDTH = BAR_WIDTH,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    level,
    output logic [31:0]      xfer_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_level;
    bar_xfer_cnt_t    r_xfer_count;
    logic             w_empty, w_full, w_push, w_pop;
    logic [WIDTH-1:0] w_rdata;

    // MSB of each pointer is the wrap bit: equal lows with differing wraps means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full && !flush;
    assign w_pop     = !w_empty && out_ready && !flush;

    bar_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Storage is not reset, so mask stale contents while empty.
    assign out_data   = w_empty ? '0 : w_rdata;
    assign level      = r_level;
    assign xfer_count = r_xfer_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_xfer_count <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + PW'(1);
                r_xfer_count <= r_xfer_count + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + CW'(1);
                2'b01:   r_level <= r_level - CW'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: tb/tb_bar_stream_source.sv
// Directed bench for bar_stream_source: one task per scenario, inline checks.
module tb_bar_stream_source;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [2:0]  level;
    logic [31:0] xfer_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_xfer = 32'd0;

    bar_stream_source #(.WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_tests++; if (xfer_count !== 32'd0) begin n_fail++; $display("FAIL reset_xfer got %0d want 0", xfer_count); end
    endtask

    task automatic test_single_hold();
        out_ready = 1'b0;
        push(32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || level !== 3'd1) begin
                n_fail++; $display("FAIL hold_%0d got v=%0b d=%h l=%0d want v=1 d=deadbeef l=1", i, out_valid, out_data, level);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_xfer = exp_xfer + 1;
        n_tests++; if (xfer_count !== exp_xfer) begin n_fail++; $display("FAIL single_xfer got %0d want %0d", xfer_count, exp_xfer); end
        n_tests++; if (out_valid !== 1'b0 || level !== 3'd0) begin
            n_fail++; $display("FAIL single_drain got v=%0b l=%0d want v=0 l=0", out_valid, level);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(32'(i));
        n_tests++; if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_flags got l=%0d rdy=%0b want l=4 rdy=0", level, in_ready);
        end
        push(32'h5);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_ignore got l=%0d want 4", level); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                n_fail++; $display("FAIL drain_%0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, 32'(i));
            end
            step();
        end
        out_ready = 1'b0;
        exp_xfer = exp_xfer + 4;
        n_tests++; if (xfer_count !== exp_xfer || out_valid !== 1'b0 || level !== 3'd0) begin
            n_fail++; $display("FAIL drain_end got x=%0d v=%0b l=%0d want x=%0d v=0 l=0", xfer_count, out_valid, level, exp_xfer);
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(32'(i));
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        exp_xfer = exp_xfer + 1;
        n_tests++; if (level !== 3'd3 || in_ready !== 1'b1 || out_data !== 32'h2) begin
            n_fail++; $display("FAIL fullpp got l=%0d rdy=%0b d=%h want l=3 rdy=1 d=2", level, in_ready, out_data);
        end
        step(); step(); step();
        out_ready = 1'b0;
        exp_xfer = exp_xfer + 3;
        n_tests++; if (out_valid !== 1'b0 || xfer_count !== exp_xfer) begin
            n_fail++; $display("FAIL fullpp_end got v=%0b x=%0d want v=0 x=%0d", out_valid, xfer_count, exp_xfer);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h10 + 32'(i);
            step();
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(i) || level !== 3'd1) begin
                n_fail++; $display("FAIL stream_%0d got v=%0b d=%h l=%0d want v=1 d=%h l=1", i, out_valid, out_data, level, 32'h10 + 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        exp_xfer = exp_xfer + 16;
        n_tests++; if (xfer_count !== exp_xfer || level !== 3'd0) begin
            n_fail++; $display("FAIL stream_end got x=%0d l=%0d want x=%0d l=0", xfer_count, level, exp_xfer);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(32'hA); push(32'hB); push(32'hC);
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL flush_pre got l=%0d want 3", level); end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (level !== 3'd0 || out_valid !== 1'b0 || xfer_count !== exp_xfer || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush got l=%0d v=%0b x=%0d rdy=%0b want l=0 v=0 x=%0d rdy=1", level, out_valid, xfer_count, in_ready, exp_xfer);
        end
        step();
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            n_fail++; $display("FAIL flush_noenq got v=%0b d=%h want v=0 d=0", out_valid, out_data);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push(32'h111); push(32'h222);
        n_tests++; if (level !== 3'd2 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre got l=%0d v=%0b want l=2 v=1", level, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        exp_xfer = 32'd0;
        n_tests++; if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 32'd0 || xfer_count !== exp_xfer) begin
            n_fail++; $display("FAIL areset got v=%0b l=%0d d=%h x=%0d want v=0 l=0 d=0 x=0", out_valid, level, out_data, xfer_count);
        end
        #2 rst = 1'b0;
        push(32'h12345678);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h12345678 || level !== 3'd1) begin
            n_fail++; $display("FAIL areset_after got v=%0b d=%h l=%0d want v=1 d=12345678 l=1", out_valid, out_data, level);
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_full();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bar_stream_source.md
Name: bar_stream_source

Overview:
- Producer end of the bar interface: drives bar.data and bar.valid, and samples bar.ready.
- Accepts words from a local push port into a DEPTH-entry FIFO.
- Presents the oldest word on the interface and holds it stable until the handshake (valid & ready) completes.
- Instantiated beside a bar interface instance in the parent; the parent wires out_* to x.data, x.valid and x.ready.

Parameters:
- WIDTH, 32, data word width; must equal the width of bar.data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the level output; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous clear of all FIFO contents.
- in_valid  in  1  local producer has a word.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  WIDTH  word to enqueue.
- out_data  out  WIDTH  drives bar.data.
- out_valid  out  1  drives bar.valid.
- out_ready  in  1  from bar.ready.
- level  out  CW  current occupancy, 0..DEPTH.
- xfer_count  out  32  completed interface handshakes, wraps modulo 2^32.

Behaviour:
- Reset (rst high, asynchronous, takes effect without a clock edge):
  - rd_ptr = wr_ptr = 0; level = 0; out_valid = 0; out_data = 0; xfer_count = 0; in_ready = 1.
  - Storage array is not reset.
  - Reset asserted mid-transfer discards all queued words. The consumer sees valid drop immediately; no handshake is counted for that cycle.
- Pointers:
  - rd_ptr and wr_ptr are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty when the pointers are fully equal.
  - full when the low bits are equal and the MSBs differ.
  - Both pointers wrap naturally from DEPTH-1 back to 0 with the wrap bit toggling.
- Push: when in_valid & in_ready, write in_data to mem[wr_ptr] and increment wr_ptr.
  - in_ready = !full, combinational from registered state only, never from in_valid.
- Pop: when out_valid & out_ready, increment rd_ptr and xfer_count.
- Output path:
  - out_valid = !empty.
  - out_data = mem[rd_ptr low bits] when !empty, else 0.
- Latency: a word pushed at edge k appears on out_data/out_valid after edge k, i.e. one cycle minimum. There is no combinational bypass from in_data to out_data.
- Interface rules:
  - Once out_valid is high, it stays high and out_data stays stable until the cycle out_ready is sampled high. Flush and reset are the only exceptions.
  - out_valid never depends combinationally on out_ready.
- Simultaneous push and pop:
  - When neither full nor empty, both occur in the same cycle and level is unchanged.
  - When empty, only the push occurs; level becomes 1.
  - When full, in_ready = 0 so only the pop occurs; in_ready rises the next cycle.
- level: registered; +1 on push only, -1 on pop only, unchanged on both or neither. It must always equal wr_ptr - rd_ptr.
- flush (sampled at the edge):
  - Sets rd_ptr = wr_ptr = 0 and level = 0.
  - Flush has priority: a push or pop in the same cycle is discarded.
  - xfer_count is not cleared and does not count a handshake in a flushed cycle.
- xfer_count: 32-bit unsigned; 0xFFFFFFFF + 1 = 0.

Decomposition:
- Package bar_pkg:
  - localparam BAR_WIDTH = 32.
  - typedef logic [BAR_WIDTH-1:0] bar_word_t.
  - typedef for the 32-bit xfer counter.
  - Shared with the consumer side.
- Sub-module bar_fifo_ram: DEPTH x WIDTH register array.
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port (raddr, rdata).
  - No reset.
- Pointer, flag, level and counter logic live in bar_stream_source.

Test Plan:
- Reset then idle, out_ready=1:
  - Expect out_valid=0, out_data=0, level=0, in_ready=1, xfer_count=0.
- Push 0xDEADBEEF with out_ready=0:
  - Next cycle out_valid=1, out_data=0xDEADBEEF, level=1.
  - Both hold for 5 cycles.
  - Raise out_ready for 1 cycle: xfer_count=1, out_valid=0, level=0.
- Push 4 words 0x1..0x4 with out_ready=0:
  - level=4, in_ready=0.
  - A 5th push of 0x5 is ignored.
  - Drain with out_ready=1: data 0x1,0x2,0x3,0x4 on consecutive cycles, xfer_count=4.
- Continuous push 0x10..0x1F with out_ready=1:
  - Output is 0x10..0x1F, one per cycle, one cycle behind input.
  - level stays 1.
  - Pointer wrap occurs with no loss or reordering.
- level=3, flush asserted together with in_valid (0xAA) and out_ready:
  - Next cycle level=0, out_valid=0, xfer_count unchanged, 0xAA not enqueued.
- level=2, out_valid=1, rst pulsed asynchronously between edges:
  - out_valid=0 and level=0 immediately.
  - After release, a new push produces a correct first word.
